random_stim_harness: RTL and testbench

- Parametrised stimulus/observation harness for out-of-context benchmark designs.
- Drives NUM_CH independent pseudo-random operand buses of WIDTH bits into a DUT and compresses the DUT result bus into a MISR signature.
- Bitstreams keep all DUT logic without tool pruning, and runs are repeatable.
- Adds run control, warm-up for DUT latency, a bounded run length and a done flag.

---
 rtl/random_stim_pkg.sv | 25 ++
 rtl/random_stim_harness_lfsr32_slice.sv | 21 ++
 rtl/random_stim_harness.sv | 118 +++++++++++
 tb/tb_random_stim_harness.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/random_stim_pkg.sv
// Shared constants, state type and LFSR helpers for random_stim_harness.
// Seeds and the LFSR step live here so every slice derives them the same way.
package random_stim_pkg;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] SEED_MIX  = 32'h9E37_79B9;

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DONE} state_t;

    function automatic logic [31:0] seed_of(
        input logic [31:0] base,
        input logic [31:0] stride,
        input int unsigned c,
        input int unsigned k
    );
        logic [31:0] s;
        s = base + 32'(c) * stride + 32'(k) * SEED_MIX;
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr32_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/random_stim_harness_lfsr32_slice.sv
// One 32-bit Galois right-shift LFSR slice of a stimulus channel.
// Reloads its seed on reset and advances only when step is high.
module lfsr32_slice
    import random_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [31:0] out
);

    always_ff @(posedge clk) begin
        if (reset)
            out <= SEED;
        else if (step)
            out <= lfsr32_step(out);
    end

endmodule

// File: rtl/random_stim_harness.sv
// Pseudo-random stimulus driver and MISR result compressor with run control.
// Optional hold input enabled by defining RANDOM_STIM_HARNESS_HOLD_EN.
module random_stim_harness
    import random_stim_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int WIDTH         = 128,
    parameter int IN_WIDTH      = 128,
    parameter int MISR_WIDTH    = 128,
    parameter int SEED_BASE     = 3,
    parameter int SEED_STRIDE   = 14,
    parameter int WARMUP_CYCLES = 4,
    parameter int RUN_CYCLES    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
`ifdef RANDOM_STIM_HARNESS_HOLD_EN
    input  logic                    hold,
`endif
    input  logic [IN_WIDTH-1:0]     dut_out,
    output logic [NUM_CH*WIDTH-1:0] stim,
    output logic [MISR_WIDTH-1:0]   signature,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             cycle_cnt
);

    localparam int SLICES = WIDTH / 32;
    localparam int NCHUNK = (IN_WIDTH + MISR_WIDTH - 1) / MISR_WIDTH;
    localparam logic [31:0] WARM_LAST = 32'(WARMUP_CYCLES - 1);
    localparam logic [31:0] RUN_LAST  = 32'(RUN_CYCLES - 1);

    state_t                         state;
    logic [31:0]                    wcnt;
    logic                           frz;
    logic                           step;
    logic [NCHUNK*MISR_WIDTH-1:0]   padded;
    logic [MISR_WIDTH-1:0]          fold;
    logic [MISR_WIDTH-1:0]          misr_next;

`ifdef RANDOM_STIM_HARNESS_HOLD_EN
    assign frz = hold && (state == WARMUP || state == RUN);
`else
    assign frz = 1'b0;
`endif

    // The first step happens on the same edge that leaves IDLE.
    assign step = !frz &&
                  ((state == IDLE && start) ||
                   state == WARMUP || state == RUN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar k = 0; k < SLICES; k++) begin : g_sl
            lfsr32_slice #(
                .SEED(seed_of(32'(SEED_BASE), 32'(SEED_STRIDE), c, k))
            ) u_slice (
                .clk  (clk),
                .reset(reset),
                .step (step),
                .out  (stim[(c*SLICES+k)*32 +: 32])
            );
        end
    end

    always_comb begin
        padded = '0;
        padded[IN_WIDTH-1:0] = dut_out;
        fold = '0;
        for (int i = 0; i < NCHUNK; i++)
            fold = fold ^ padded[i*MISR_WIDTH +: MISR_WIDTH];
        misr_next = {signature[MISR_WIDTH-2:0], 1'b0}
                  ^ (signature[MISR_WIDTH-1] ?
                     {(MISR_WIDTH/32){LFSR_TAPS}} : '0)
                  ^ fold;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            signature <= '0;
            cycle_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (!frz) begin
            unique case (state)
                IDLE: if (start) begin
                    signature <= '0;
                    cycle_cnt <= '0;
                    wcnt      <= '0;
                    busy      <= 1'b1;
                    state     <= (WARMUP_CYCLES == 0) ? RUN : WARMUP;
                end
                WARMUP: begin
                    wcnt <= wcnt + 32'd1;
                    if (wcnt == WARM_LAST)
                        state <= RUN;
                end
                RUN: begin
                    signature <= misr_next;
                    cycle_cnt <= cycle_cnt + 32'd1;
                    if (RUN_CYCLES != 0 && cycle_cnt == RUN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: if (start) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_random_stim_harness.sv
// Self-checking bench for random_stim_harness: directed vectors, corner
// sequences and randomized traffic against a phase-counting reference model.
module tb_random_stim_harness;

    localparam int NC = 2;
    localparam int W  = 128;
    localparam int IW = 128;
    localparam int MW = 128;
    localparam int WU = 4;
    localparam int RC = 8;
    localparam int NS = NC * W / 32;
`ifdef RANDOM_STIM_HARNESS_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam logic [127:0] ONES = {128{1'b1}};

    logic          clk = 1'b0;
    logic          reset, start, hold;
    logic [IW-1:0] dut_out;
    logic [NC*W-1:0] stim;
    logic [MW-1:0] signature;
    logic          busy, done;
    logic [31:0]   cycle_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    random_stim_harness #(
        .NUM_CH(NC), .WIDTH(W), .IN_WIDTH(IW), .MISR_WIDTH(MW),
        .SEED_BASE(3), .SEED_STRIDE(14),
        .WARMUP_CYCLES(WU), .RUN_CYCLES(RC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef RANDOM_STIM_HARNESS_HOLD_EN
        .hold     (hold),
`endif
        .dut_out  (dut_out),
        .stim     (stim),
        .signature(signature),
        .busy     (busy),
        .done     (done),
        .cycle_cnt(cycle_cnt)
    );

    // Reference model: run phase p counts stimulus edges since start.
    logic [31:0]   m_lfsr [NS];
    logic [MW-1:0] m_sig;
    logic [31:0]   m_cnt;
    int            m_mode;
    int            m_p;

    function automatic logic [31:0] mstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] mseed(input int c, input int k);
        logic [31:0] s;
        s = 32'd3 + 32'(c) * 32'd14 + 32'(k) * 32'h9E37_79B9;
        return (s == 0) ? 32'd1 : s;
    endfunction

    function automatic logic [MW-1:0] mmisr(input logic [MW-1:0] s,
                                            input logic [IW-1:0] d);
        logic [MW-1:0] r;
        r = s << 1;
        if (s[MW-1]) r = r ^ {(MW/32){32'h8020_0003}};
        return r ^ d;
    endfunction

    task automatic model_edge(input logic rst, input logic st,
                              input logic [IW-1:0] d, input logic h);
        if (rst) begin
            for (int i = 0; i < NS; i++) m_lfsr[i] = mseed(i / (W/32), i % (W/32));
            m_sig = '0; m_cnt = 0; m_mode = 0; m_p = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                m_sig = '0; m_cnt = 0;
                for (int i = 0; i < NS; i++) m_lfsr[i] = mstep(m_lfsr[i]);
                m_p = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (!(HOLD_EN && h)) begin
                if (m_p >= WU + 1) begin
                    m_sig = mmisr(m_sig, d);
                    m_cnt = m_cnt + 1;
                end
                for (int i = 0; i < NS; i++) m_lfsr[i] = mstep(m_lfsr[i]);
                m_p++;
                if (m_p > WU + RC) m_mode = 2;
            end
        end else if (st) begin
            m_mode = 0;
        end
    endtask

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [NC*W-1:0] es;
        for (int i = 0; i < NS; i++) es[i*32 +: 32] = m_lfsr[i];
        chk("stim", stim, es);
        chk("signature", signature, m_sig);
        chk("busy", busy, m_mode == 1);
        chk("done", done, m_mode == 2);
        chk("cycle_cnt", cycle_cnt, m_cnt);
    endtask

    task automatic cyc(input logic rst, input logic st,
                       input logic [IW-1:0] d, input logic h);
        reset = rst; start = st; dut_out = d; hold = h;
        @(posedge clk);
        model_edge(rst, st, d, h);
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [IW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic rst; logic st; logic [127:0] d; logic cs;
        logic [31:0] s0; logic [31:0] s1; logic [127:0] sig;
        logic busy; logic done; logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic st,
                                 input logic [127:0] d, input logic cs,
                                 input logic [31:0] s0, input logic [31:0] s1,
                                 input logic [127:0] sig, input logic b,
                                 input logic dn, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.st = st; v.d = d; v.cs = cs; v.s0 = s0; v.s1 = s1;
        v.sig = sig; v.busy = b; v.done = dn; v.cnt = cnt;
        return v;
    endfunction

    logic [IW-1:0] gdata [WU+RC+1];

    // Full run from IDLE; optional 5-cycle hold starting at edge hold_at.
    task automatic run_full(input int hold_at, output logic [MW-1:0] sig);
        logic [NC*W-1:0] ss;
        logic [MW-1:0]   sg;
        logic [31:0]     sc;
        cyc(1'b0, 1'b1, gdata[0], 1'b0);
        for (int e = 1; e <= WU + RC; e++) begin
            if (e == hold_at) begin
                ss = stim; sg = signature; sc = cycle_cnt;
                repeat (5) begin
                    cyc(1'b0, 1'b0, rnd(), 1'b1);
                    chk("hold_stim", stim, ss);
                    chk("hold_sig", signature, sg);
                    chk("hold_cnt", cycle_cnt, sc);
                end
            end
            cyc(1'b0, 1'b0, gdata[e], 1'b0);
        end
        chk("run_done", done, 1'b1);
        sig = signature;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        int n;
        logic [NC*W-1:0] sv;
        logic [MW-1:0]   ss, gsig, rsig;

        tbl[0] = mkv(1, 0, '0,   1, 32'h3, 32'h11, '0, 0, 0, 0);
        tbl[1] = mkv(1, 0, ONES, 1, 32'h3, 32'h11, '0, 0, 0, 0);
        tbl[2] = mkv(0, 1, ONES, 1, 32'h8020_0002, 32'h8020_000B, '0, 1, 0, 0);
        tbl[3] = mkv(0, 0, ONES, 0, 0, 0, '0, 1, 0, 0);
        tbl[4] = mkv(0, 1, ONES, 0, 0, 0, '0, 1, 0, 0);
        tbl[5] = mkv(0, 0, ONES, 0, 0, 0, '0, 1, 0, 0);
        tbl[6] = mkv(0, 0, ONES, 0, 0, 0, '0, 1, 0, 0);
        tbl[7] = mkv(0, 0, ONES, 0, 0, 0, ONES, 1, 0, 1);

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].d, 1'b0);
            if (tbl[i].cs) begin
                chk("vec_stim0", stim[31:0], tbl[i].s0);
                chk("vec_stim_ch1", stim[159:128], tbl[i].s1);
            end
            chk("vec_sig", signature, tbl[i].sig);
            chk("vec_busy", busy, tbl[i].busy);
            chk("vec_done", done, tbl[i].done);
            chk("vec_cnt", cycle_cnt, tbl[i].cnt);
        end

        // Edges 0..5 are behind us; done must rise after edge 12.
        n = 5;
        while (!done && n < 60) begin
            cyc(1'b0, $urandom % 2 == 0, rnd(), 1'b0);
            n++;
        end
        chk("done_latency", n, WU + RC);

        sv = stim; ss = signature;
        cyc(1'b0, 1'b1, rnd(), 1'b0);
        chk("no_reseed", stim, sv);
        chk("done_sig_kept", signature, ss);
        chk("done_cnt_kept", cycle_cnt, RC);
        cyc(1'b0, 1'b0, rnd(), 1'b0);
        chk("idle_hold", stim, sv);

        // Zero-data bounded run.
        cyc(1'b0, 1'b1, '0, 1'b0);
        n = 0;
        while (!done && n < 60) begin
            cyc(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        chk("zero_done_at", n, WU + RC);
        chk("zero_sig", signature, 128'h0);
        chk("zero_cnt", cycle_cnt, RC);

        // Abort in the middle of RUN.
        cyc(1'b0, 1'b1, rnd(), 1'b0);
        cyc(1'b0, 1'b1, rnd(), 1'b0);
        for (int e = 1; e <= WU + 3; e++) cyc(1'b0, 1'b0, rnd(), 1'b0);
        cyc(1'b1, 1'b0, rnd(), 1'b0);
        chk("abort_stim0", stim[31:0], 32'h3);
        chk("abort_stim_ch1", stim[159:128], 32'h11);
        chk("abort_sig", signature, 128'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_cnt", cycle_cnt, 32'h0);

        for (int i = 0; i <= WU + RC; i++) gdata[i] = rnd();
        cyc(1'b0, 1'b0, rnd(), 1'b0);
        run_full(-1, gsig);
        cyc(1'b1, 1'b0, rnd(), 1'b0);
        run_full(-1, rsig);
        chk("repeat_sig", rsig, gsig);

`ifdef RANDOM_STIM_HARNESS_HOLD_EN
        cyc(1'b1, 1'b0, rnd(), 1'b0);
        run_full(WU + 3, rsig);
        chk("hold_final_sig", rsig, gsig);
`endif

        cyc(1'b1, 1'b0, rnd(), 1'b0);
        for (int i = 0; i < 400; i++)
            cyc($urandom % 60 == 0, $urandom % 4 == 0, rnd(),
                $urandom % 3 == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
